// File: rtl/update_knn_mul_acc.sv
// +----------------------------------------------------------------------------+
// | update_knn_mul_acc : pipelined multiplier with optional grouped accumulate  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module update_knn_mul_acc #(
  parameter int DIN0_WIDTH = 17,
  parameter int DIN1_WIDTH = 15,
  parameter int DOUT_WIDTH = 40,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0,
  parameter int ACC_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_clr,
  input  logic                  acc_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_ovf
);

  localparam int c_prod_w = DIN0_WIDTH + DIN1_WIDTH;
  localparam int c_pipe   = NUM_STAGE - 1;

  if (DOUT_WIDTH < c_prod_w) begin : g_chk_dout
    $error("update_knn_mul_acc: DOUT_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH");
  end
  if (NUM_STAGE < 2) begin : g_chk_stage
    $error("update_knn_mul_acc: NUM_STAGE must be >= 2");
  end

  // Data and group flags only load on valid beats so outputs hold through bubbles.
  logic [DIN0_WIDTH-1:0] a_q, a_d;
  logic [DIN1_WIDTH-1:0] b_q, b_d;
  logic                  v1_q, v1_d, clr1_q, clr1_d, last1_q, last1_d;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    clr1_d  = clr1_q;
    last1_d = last1_q;
    v1_d    = in_valid;
    if (in_valid) begin
      a_d     = din0;
      b_d     = din1;
      clr1_d  = acc_clr;
      last1_d = acc_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      clr1_q  <= 1'b0;
      last1_q <= 1'b0;
    end else if (ce) begin
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= v1_d;
      clr1_q  <= clr1_d;
      last1_q <= last1_d;
    end
  end

  // Sign-extending both operands to the product width yields the correct
  // two's-complement product from a plain modular multiply.
  logic [c_prod_w-1:0] a_ext, b_ext, prod;
  assign a_ext = {{DIN1_WIDTH{(SIGNED != 0) && a_q[DIN0_WIDTH-1]}}, a_q};
  assign b_ext = {{DIN0_WIDTH{(SIGNED != 0) && b_q[DIN1_WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  logic [c_prod_w-1:0] p_q [c_pipe];
  logic [c_prod_w-1:0] p_d [c_pipe];
  logic [c_pipe-1:0]   pv_q, pv_d, pc_q, pc_d, pl_q, pl_d;

  always_comb begin
    pv_d = pv_q;
    pc_d = pc_q;
    pl_d = pl_q;
    for (int k = 0; k < c_pipe; k++) p_d[k] = p_q[k];
    pv_d[0] = v1_q;
    if (v1_q) begin
      p_d[0]  = prod;
      pc_d[0] = clr1_q;
      pl_d[0] = last1_q;
    end
    for (int k = 1; k < c_pipe; k++) begin
      pv_d[k] = pv_q[k-1];
      if (pv_q[k-1]) begin
        p_d[k]  = p_q[k-1];
        pc_d[k] = pc_q[k-1];
        pl_d[k] = pl_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pc_q <= '0;
      pl_q <= '0;
      for (int k = 0; k < c_pipe; k++) p_q[k] <= '0;
    end else if (ce) begin
      pv_q <= pv_d;
      pc_q <= pc_d;
      pl_q <= pl_d;
      for (int k = 0; k < c_pipe; k++) p_q[k] <= p_d[k];
    end
  end

  logic                  tail_v, tail_clr, tail_last;
  logic [c_prod_w-1:0]   tail_p;
  logic [DOUT_WIDTH-1:0] prod_ext;
  assign tail_v    = pv_q[c_pipe-1];
  assign tail_clr  = pc_q[c_pipe-1];
  assign tail_last = pl_q[c_pipe-1];
  assign tail_p    = p_q[c_pipe-1];

  if (DOUT_WIDTH > c_prod_w) begin : g_ext_pad
    assign prod_ext = {{(DOUT_WIDTH-c_prod_w){(SIGNED != 0) && tail_p[c_prod_w-1]}}, tail_p};
  end else begin : g_ext_none
    assign prod_ext = tail_p;
  end

  if (ACC_EN != 0) begin : g_acc
    logic [DOUT_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d;
    logic                  ovf_q, ovf_d, ovalid_q, ovalid_d;
    logic                  olast_q, olast_d, oovf_q, oovf_d;
    logic [DOUT_WIDTH:0]   sum;
    logic                  add_ovf;

    always_comb begin
      sum = {1'b0, acc_q} + {1'b0, prod_ext};
      if (SIGNED != 0) begin
        add_ovf = (acc_q[DOUT_WIDTH-1] == prod_ext[DOUT_WIDTH-1]) &&
                  (sum[DOUT_WIDTH-1] != acc_q[DOUT_WIDTH-1]);
      end else begin
        add_ovf = sum[DOUT_WIDTH];
      end
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      dout_d   = dout_q;
      olast_d  = olast_q;
      oovf_d   = oovf_q;
      ovalid_d = 1'b0;
      if (tail_v) begin
        if (tail_clr) begin
          acc_d = prod_ext;
          ovf_d = 1'b0;
        end else begin
          acc_d = sum[DOUT_WIDTH-1:0];
          ovf_d = ovf_q | add_ovf;
        end
        if (tail_last) begin
          ovalid_d = 1'b1;
          dout_d   = acc_d;
          oovf_d   = ovf_d;
          olast_d  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q    <= '0;
        ovf_q    <= 1'b0;
        dout_q   <= '0;
        ovalid_q <= 1'b0;
        olast_q  <= 1'b0;
        oovf_q   <= 1'b0;
      end else if (ce) begin
        acc_q    <= acc_d;
        ovf_q    <= ovf_d;
        dout_q   <= dout_d;
        ovalid_q <= ovalid_d;
        olast_q  <= olast_d;
        oovf_q   <= oovf_d;
      end
    end

    assign dout      = dout_q;
    assign out_valid = ovalid_q;
    assign out_last  = olast_q;
    assign out_ovf   = oovf_q;
  end else begin : g_noacc
    logic unused_clr;
    assign unused_clr = tail_clr;
    assign dout       = prod_ext;
    assign out_valid  = tail_v;
    assign out_last   = tail_last;
    assign out_ovf    = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_update_knn_mul_acc.sv
// +----------------------------------------------------------------------------+
// | tb_update_knn_mul_acc : directed table bench over four parameter sets       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_update_knn_mul_acc;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, acc_clr, acc_last;
  logic [16:0] din0;
  logic [14:0] din1;
  logic [39:0] d_def, d_sgn, d_nac;
  logic [31:0] d_w32;
  logic [3:0]  ov, ol, oo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: SIGNED=1, 2: ACC_EN=0, 3: DOUT_WIDTH=32
  update_knn_mul_acc u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_clr(acc_clr), .acc_last(acc_last), .dout(d_def), .out_valid(ov[0]),
    .out_last(ol[0]), .out_ovf(oo[0]));

  update_knn_mul_acc #(.SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_clr(acc_clr), .acc_last(acc_last), .dout(d_sgn), .out_valid(ov[1]),
    .out_last(ol[1]), .out_ovf(oo[1]));

  update_knn_mul_acc #(.ACC_EN(0)) u_nac (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_clr(acc_clr), .acc_last(acc_last), .dout(d_nac), .out_valid(ov[2]),
    .out_last(ol[2]), .out_ovf(oo[2]));

  update_knn_mul_acc #(.DOUT_WIDTH(32)) u_w32 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_clr(acc_clr), .acc_last(acc_last), .dout(d_w32), .out_valid(ov[3]),
    .out_last(ol[3]), .out_ovf(oo[3]));

  typedef struct {
    logic        ce, v;
    logic [16:0] a;
    logic [14:0] b;
    logic        clr, last;
    int          sel;
    logic        ev;
    logic [39:0] ed;
    logic        el, eo;
  } vec_t;

  localparam int NV = 36;
  vec_t tv [NV];

  function automatic vec_t mk(logic ce_i, logic v_i, logic [16:0] a_i, logic [14:0] b_i,
                              logic clr_i, logic last_i, int sel_i, logic ev_i,
                              logic [39:0] ed_i, logic el_i, logic eo_i);
    vec_t r;
    r.ce = ce_i; r.v = v_i; r.a = a_i; r.b = b_i; r.clr = clr_i; r.last = last_i;
    r.sel = sel_i; r.ev = ev_i; r.ed = ed_i; r.el = el_i; r.eo = eo_i;
    return r;
  endfunction

  function automatic logic [39:0] get_dout(int s);
    case (s)
      0:       return d_def;
      1:       return d_sgn;
      2:       return d_nac;
      default: return {8'h00, d_w32};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce_i, input logic v_i, input logic [16:0] a_i,
                       input logic [14:0] b_i, input logic clr_i, input logic last_i);
    ce = ce_i; in_valid = v_i; din0 = a_i; din1 = b_i; acc_clr = clr_i; acc_last = last_i;
  endtask

  initial begin
    int lat;
    bit seen;

    for (int i = 0; i < NV; i++) tv[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // grouped sum 3*4+5*6+7*8
    tv[0]  = mk(1, 1, 3, 4, 1, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(1, 1, 7, 8, 0, 1, 0, 0, 0, 0, 0);
    tv[5]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 40'd98, 1, 0);
    // bubble inside group A, group B directly after A
    tv[7]  = mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[9]  = mk(1, 1, 2, 2, 0, 1, 0, 0, 0, 0, 0);
    tv[10] = mk(1, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
    tv[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 40'd5, 1, 0);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 40'd9, 1, 0);
    // signed -2 * 3
    tv[15] = mk(1, 1, 17'h1FFFE, 3, 1, 1, 1, 0, 0, 0, 0);
    tv[16] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[17] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[18] = mk(1, 0, 0, 0, 0, 0, 1, 1, 40'hFF_FFFF_FFFA, 1, 0);
    // 32-bit accumulator overflow, then a clean single-beat group
    tv[19] = mk(1, 1, 17'h1FFFF, 15'h7FFF, 1, 0, 3, 0, 0, 0, 0);
    tv[20] = mk(1, 1, 17'h1FFFF, 15'h7FFF, 0, 1, 3, 0, 0, 0, 0);
    tv[21] = mk(1, 1, 2, 2, 1, 1, 3, 0, 0, 0, 0);
    tv[22] = mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    tv[23] = mk(1, 0, 0, 0, 0, 0, 3, 1, 40'hFFFB_0002, 1, 1);
    tv[24] = mk(1, 0, 0, 0, 0, 0, 3, 1, 40'd4, 1, 0);
    // plain multiplier with two ce stalls
    tv[25] = mk(1, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0);
    tv[26] = mk(1, 1, 2, 3, 0, 0, 2, 0, 0, 0, 0);
    for (int i = 27; i < 30; i++) tv[i] = mk(0, 1, 17'h1FFFF, 15'h7FFF, 0, 0, 2, 0, 0, 0, 0);
    tv[30] = mk(1, 1, 17'h1FFFF, 15'h7FFF, 0, 0, 2, 1, 40'd1, 0, 0);
    tv[31] = mk(1, 0, 0, 0, 0, 0, 2, 1, 40'd6, 0, 0);
    tv[32] = mk(0, 0, 0, 0, 0, 0, 2, 1, 40'd6, 0, 0);
    tv[33] = mk(0, 0, 0, 0, 0, 0, 2, 1, 40'd6, 0, 0);
    tv[34] = mk(1, 0, 0, 0, 0, 0, 2, 1, 40'hFFFD_8001, 0, 0);
    tv[35] = mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);

    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset_dout%0d", s), {24'h0, get_dout(s)}, 64'h0);
      chk($sformatf("reset_valid%0d", s), {63'h0, ov[s]}, 64'h0);
      chk($sformatf("reset_last%0d", s), {63'h0, ol[s]}, 64'h0);
      chk($sformatf("reset_ovf%0d", s), {63'h0, oo[s]}, 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].ce, tv[i].v, tv[i].a, tv[i].b, tv[i].clr, tv[i].last);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), {63'h0, ov[tv[i].sel]}, {63'h0, tv[i].ev});
      if (tv[i].ev) begin
        chk($sformatf("row%0d_dout", i), {24'h0, get_dout(tv[i].sel)}, {24'h0, tv[i].ed});
        chk($sformatf("row%0d_last", i), {63'h0, ol[tv[i].sel]}, {63'h0, tv[i].el});
        chk($sformatf("row%0d_ovf", i), {63'h0, oo[tv[i].sel]}, {63'h0, tv[i].eo});
      end
      @(negedge clk);
    end

    // reset while a group is in flight
    drive(1, 1, 10, 10, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dout", {24'h0, d_def}, 64'h0);
    chk("midrst_valid", {63'h0, ov[0]}, 64'h0);
    chk("midrst_last", {63'h0, ol[0]}, 64'h0);
    chk("midrst_ovf", {63'h0, oo[0]}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_quiet%0d", i), {63'h0, ov[0]}, 64'h0);
    end
    @(negedge clk);
    drive(1, 1, 2, 2, 0, 1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ov[0]) begin
        seen = 1'b1;
        lat  = i;
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
    end
    chk("postrst_seen", {63'h0, seen}, 64'h1);
    chk("postrst_latency", lat, 4);
    chk("postrst_dout", {24'h0, d_def}, 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
